reg_file: RTL and testbench
===========================

# reg_file

Architectural register file for the CSE141L processor, sitting on both sides of the ALU. It feeds ALU operands A and B through two read ports and consumes the ALU's two result words (primary result and secondary/remainder) through two write ports. It also latches the ALU's zero indication into a status flag for the branch logic. All state updates occur on one clock edge; reads are combinational, with same-cycle write bypass.

## Interface
Parameters:
- W, 16, data width in bits
- A, 4, address width; depth = 2**A registers

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- ReadAddrA  in  A  register index for ALU operand A
- ReadAddrB  in  A  register index for ALU operand B
- DataOutA  out  W  value of register ReadAddrA, combinational
- DataOutB  out  W  value of register ReadAddrB, combinational
- WriteEn1  in  1  commit WriteData1 to WriteAddr1
- WriteAddr1  in  A  destination of primary ALU result
- WriteData1  in  W  primary ALU result
- WriteEn2  in  1  commit WriteData2 to WriteAddr2
- WriteAddr2  in  A  destination of secondary ALU result (division remainder)
- WriteData2  in  W  secondary ALU result
- ZeroIn  in  1  ALU zero indication, latched unmodified
- FlagEn  in  1  update ZeroFlag this cycle
- ZeroFlag  out  1  latched status flag, registered

## Operation
- Storage: 2**A words of W bits each, plus a 1-bit ZeroFlag register.
- Register 0 is hardwired to 0. Reads of index 0 always return 0. Writes to index 0 are discarded on both ports.
- Write port 1: on a rising Clk with WriteEn1=1 and Reset=0, reg[WriteAddr1] <= WriteData1.
- Write port 2: same rule for WriteEn2, WriteAddr2 and WriteData2.
- Write collision (WriteEn1=WriteEn2=1 and WriteAddr1==WriteAddr2, nonzero): port 1 wins and port 2's data is dropped for that cycle.
- Read bypass, applied independently to DataOutA and DataOutB, for a read index r != 0:
  - If WriteEn1=1 and WriteAddr1==r, output WriteData1.
  - Otherwise, if WriteEn2=1 and WriteAddr2==r, output WriteData2.
  - Otherwise, output the stored reg[r].
  - Bypass priority therefore matches write priority.
- Bypass is suppressed while Reset=1, and both read outputs are 0 during Reset.
- ZeroFlag: on a rising Clk with FlagEn=1 and Reset=0, ZeroFlag <= ZeroIn. Otherwise it holds its value. ZeroFlag has no bypass; the new value is visible the cycle after the update.
- Addresses are A bits wide, so no out-of-range index exists; no wrap or saturation logic is needed.

## Timing
- Reset: synchronous. A rising Clk with Reset=1 clears every register and ZeroFlag to 0, overriding any simultaneous writes or flag update.
  - While Reset is held high, DataOutA = DataOutB = 0 and ZeroFlag = 0.
  - Outputs stay 0 after Reset deasserts until the first write.
- Reset asserted mid-stream, with writes pending in the same cycle: the writes are lost, and all state reads 0 on the next cycle.
- Write latency: data is stored at the edge ending the cycle in which WriteEn is asserted.
- Read latency: 0 cycles. The bypass makes write data visible combinationally in the same cycle; the stored value is visible from the next cycle onward.
- Clk-to-out:
  - DataOutA/B depend on the register array and on the current-cycle write inputs.
  - ZeroFlag is a pure register output.
- No handshake. Every enabled write is accepted every cycle, with no stall or backpressure.

## Test plan
- Reset: preload r1..r15 with nonzero values and set ZeroFlag=1, then hold Reset for 1 edge. Expect all reads = 0x0000 and ZeroFlag = 0. Writes asserted during that reset edge must not stick.
- Basic write/read: write 0x1234 to r3 on port 1 and 0xBEEF to r7 on port 2 in the same cycle. Next cycle, ReadAddrA=3 and ReadAddrB=7 return 0x1234 and 0xBEEF.
- R0 hardwired: write 0xFFFF to r0 on both ports. In that cycle and the next, reads of index 0 return 0x0000.
- Collision: WriteEn1=WriteEn2=1, both targeting r5, with 0x00AA on port 1 and 0x0055 on port 2. DataOutA (addr 5) = 0x00AA in the same cycle, and r5 = 0x00AA afterward.
- Bypass: r9 holds 0x0001. Write 0x0002 to r9 with ReadAddrA=ReadAddrB=9. Both outputs show 0x0002 in the same cycle, before the edge.
- Flag: ZeroIn=1 with FlagEn=1 gives ZeroFlag=1 the next cycle. Then ZeroIn=0 with FlagEn=0 leaves ZeroFlag=1. Then ZeroIn=0 with FlagEn=1 gives ZeroFlag=0.

Source files
------------

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file
//  Brief    : Architectural register file for the ALU datapath. Two
//             combinational read ports with same-cycle write bypass, two
//             write ports (port 1 has priority on a collision), register 0
//             hardwired to zero, and a latched zero status flag.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int W = 16,
    parameter int A = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [A-1:0] ReadAddrA,
    input  logic [A-1:0] ReadAddrB,
    output logic [W-1:0] DataOutA,
    output logic [W-1:0] DataOutB,
    input  logic         WriteEn1,
    input  logic [A-1:0] WriteAddr1,
    input  logic [W-1:0] WriteData1,
    input  logic         WriteEn2,
    input  logic [A-1:0] WriteAddr2,
    input  logic [W-1:0] WriteData2,
    input  logic         ZeroIn,
    input  logic         FlagEn,
    output logic         ZeroFlag
);

    localparam int c_depth = 2 ** A;

    logic [W-1:0] regs_q [c_depth];
    logic [W-1:0] regs_d [c_depth];
    logic         zero_flag_q;
    logic         zero_flag_d;

    // Read path: reset forces zero, index 0 is constant zero, otherwise the
    // in-flight write (port 1 first) is forwarded ahead of the stored word.
    function automatic logic [W-1:0] f_read(input logic [A-1:0] r);
        logic [W-1:0] v;
        if (Reset || (r == '0)) begin
            v = '0;
        end else if (WriteEn1 && (WriteAddr1 == r)) begin
            v = WriteData1;
        end else if (WriteEn2 && (WriteAddr2 == r)) begin
            v = WriteData2;
        end else begin
            v = regs_q[r];
        end
        return v;
    endfunction

    // Combinational read ports with bypass.
    always_comb begin
        DataOutA = f_read(ReadAddrA);
        DataOutB = f_read(ReadAddrB);
    end

    // Next-state of the array: port 2 applied first so port 1 overwrites it
    // on a collision; register 0 is forced back to zero afterward.
    always_comb begin
        regs_d = regs_q;
        if (WriteEn2) begin
            regs_d[WriteAddr2] = WriteData2;
        end
        if (WriteEn1) begin
            regs_d[WriteAddr1] = WriteData1;
        end
        regs_d[0] = '0;
    end

    // Next-state of the zero flag: load only when enabled.
    always_comb begin
        zero_flag_d = FlagEn ? ZeroIn : zero_flag_q;
    end

    // State update; reset overrides any simultaneous write or flag load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < c_depth; i++) begin
                regs_q[i] <= '0;
            end
            zero_flag_q <= 1'b0;
        end else begin
            for (int i = 0; i < c_depth; i++) begin
                regs_q[i] <= regs_d[i];
            end
            zero_flag_q <= zero_flag_d;
        end
    end

    assign ZeroFlag = zero_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file
//  Brief    : Self-checking bench for reg_file: directed scenarios followed
//             by randomized traffic, compared against an array-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    localparam int W = 16;
    localparam int A = 4;
    localparam int c_depth = 2 ** A;

    logic         clk;
    logic         rst;
    logic [A-1:0] ra, rb;
    logic [W-1:0] dout_a, dout_b;
    logic         we1, we2;
    logic [A-1:0] wa1, wa2;
    logic [W-1:0] wd1, wd2;
    logic         zin, fen;
    logic         zflag;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [W-1:0] mem [c_depth];
    logic         zf_m;

    reg_file #(.W(W), .A(A)) dut (
        .Clk        (clk),
        .Reset      (rst),
        .ReadAddrA  (ra),
        .ReadAddrB  (rb),
        .DataOutA   (dout_a),
        .DataOutB   (dout_b),
        .WriteEn1   (we1),
        .WriteAddr1 (wa1),
        .WriteData1 (wd1),
        .WriteEn2   (we2),
        .WriteAddr2 (wa2),
        .WriteData2 (wd2),
        .ZeroIn     (zin),
        .FlagEn     (fen),
        .ZeroFlag   (zflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Expected read value from the architectural rules.
    function automatic logic [W-1:0] exp_read(input logic [A-1:0] r);
        if (rst)               return '0;
        if (r == 0)            return '0;
        if (we1 && wa1 == r)   return wd1;
        if (we2 && wa2 == r)   return wd2;
        return mem[r];
    endfunction

    task automatic idle();
        rst = 1'b0; we1 = 1'b0; we2 = 1'b0; fen = 1'b0; zin = 1'b0;
        wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0;
    endtask

    // Inputs are already applied (just after a falling edge). Check the
    // combinational outputs and flag, clock once, then advance the model.
    task automatic cycle(input string tag);
        #1;
        check({tag, "_A"}, dout_a, exp_read(ra));
        check({tag, "_B"}, dout_b, exp_read(rb));
        check({tag, "_ZF"}, {{(W-1){1'b0}}, zflag}, {{(W-1){1'b0}}, zf_m});
        @(posedge clk);
        if (rst) begin
            foreach (mem[i]) mem[i] = '0;
            zf_m = 1'b0;
        end else begin
            if (we2 && wa2 != 0 && !(we1 && wa1 == wa2)) mem[wa2] = wd2;
            if (we1 && wa1 != 0) mem[wa1] = wd1;
            if (fen) zf_m = zin;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        ra = '0; rb = '0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        foreach (mem[i]) mem[i] = '0;
        zf_m = 1'b0;
        rst  = 1'b0;

        // Preload r1..r15 with nonzero values and set the flag.
        for (int i = 1; i < c_depth; i++) begin
            idle();
            we1 = 1'b1; wa1 = A'(i); wd1 = W'(i * 16'h1111);
            fen = 1'b1; zin = 1'b1;
            ra = A'(i); rb = A'(i - 1);
            cycle("preload");
        end
        check("flag_set", {{(W-1){1'b0}}, zflag}, 16'h0001);

        // Reset with writes and flag update pending: nothing sticks.
        idle();
        rst = 1'b1; we1 = 1'b1; wa1 = 4'd3; wd1 = 16'hDEAD;
        we2 = 1'b1; wa2 = 4'd4; wd2 = 16'hCAFE; fen = 1'b1; zin = 1'b1;
        ra = 4'd3; rb = 4'd4;
        cycle("rst_hold");
        idle();
        for (int i = 0; i < c_depth; i++) begin
            ra = A'(i); rb = A'(c_depth - 1 - i);
            #1;
            check("post_rst_A", dout_a, 16'h0000);
            check("post_rst_B", dout_b, 16'h0000);
        end
        check("post_rst_ZF", {{(W-1){1'b0}}, zflag}, 16'h0000);

        // Basic dual write, then read back.
        idle();
        we1 = 1'b1; wa1 = 4'd3; wd1 = 16'h1234;
        we2 = 1'b1; wa2 = 4'd7; wd2 = 16'hBEEF;
        ra = 4'd1; rb = 4'd2;
        cycle("basic_wr");
        idle(); ra = 4'd3; rb = 4'd7;
        #1;
        check("basic_r3", dout_a, 16'h1234);
        check("basic_r7", dout_b, 16'hBEEF);
        cycle("basic_rd");

        // Writes to r0 are discarded on both ports.
        idle();
        we1 = 1'b1; wa1 = 4'd0; wd1 = 16'hFFFF;
        we2 = 1'b1; wa2 = 4'd0; wd2 = 16'hFFFF;
        ra = 4'd0; rb = 4'd0;
        #1;
        check("r0_same", dout_a, 16'h0000);
        cycle("r0_wr");
        idle(); ra = 4'd0; rb = 4'd0;
        #1;
        check("r0_next", dout_b, 16'h0000);
        cycle("r0_rd");

        // Collision on r5: port 1 wins.
        idle();
        we1 = 1'b1; wa1 = 4'd5; wd1 = 16'h00AA;
        we2 = 1'b1; wa2 = 4'd5; wd2 = 16'h0055;
        ra = 4'd5; rb = 4'd5;
        #1;
        check("coll_byp", dout_a, 16'h00AA);
        cycle("coll_wr");
        idle(); ra = 4'd5;
        #1;
        check("coll_st", dout_a, 16'h00AA);
        cycle("coll_rd");

        // Bypass on r9.
        idle(); we1 = 1'b1; wa1 = 4'd9; wd1 = 16'h0001;
        cycle("byp_pre");
        idle(); we2 = 1'b1; wa2 = 4'd9; wd2 = 16'h0002;
        ra = 4'd9; rb = 4'd9;
        #1;
        check("byp_A", dout_a, 16'h0002);
        check("byp_B", dout_b, 16'h0002);
        cycle("byp_wr");
        idle(); ra = 4'd9; rb = 4'd9;
        cycle("byp_rd");

        // Flag sequence.
        idle(); fen = 1'b1; zin = 1'b1;
        cycle("flag1");
        check("flag_on", {{(W-1){1'b0}}, zflag}, 16'h0001);
        idle(); fen = 1'b0; zin = 1'b0;
        cycle("flag2");
        check("flag_hold", {{(W-1){1'b0}}, zflag}, 16'h0001);
        idle(); fen = 1'b1; zin = 1'b0;
        cycle("flag3");
        check("flag_off", {{(W-1){1'b0}}, zflag}, 16'h0000);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            we1 = $urandom_range(0, 1) == 1;
            we2 = $urandom_range(0, 1) == 1;
            wa1 = A'($urandom_range(0, c_depth - 1));
            // Bias port 2 toward colliding with port 1.
            wa2 = ($urandom_range(0, 3) == 0) ? wa1 : A'($urandom_range(0, c_depth - 1));
            wd1 = W'($urandom);
            wd2 = W'($urandom);
            ra  = ($urandom_range(0, 2) == 0) ? wa1 : A'($urandom_range(0, c_depth - 1));
            rb  = ($urandom_range(0, 2) == 0) ? wa2 : A'($urandom_range(0, c_depth - 1));
            fen = $urandom_range(0, 1) == 1;
            zin = $urandom_range(0, 1) == 1;
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
